// File: rtl/prm_edge_chk_sched.sv
`default_nettype none
// ============================================================================
// Module      : prm_edge_chk_sched
// Description : Walks the obstacle list for one PRM roadmap query. It streams
//               obstacle voxel codes out of obstacle RAM, one per cycle, and
//               presents each code to a bank of combinational edge checkers.
//               It ORs every returned edge mask into a per-edge blocked vector
//               and reports that vector to the planner.
// Ports       : clk, rst_n          clock, asynchronous active-low reset
//               start, abort        planner request / cancel
//               obs_count, edge_en  query size and edges of interest
//               busy, done          scan in progress / result-valid pulse
//               edge_blocked        accumulated mask AND edge_en
//               mem_rd_en, mem_addr, mem_rdata   obstacle RAM port
//               chk_code, chk_valid, chk_mask    checker bank port
// Revision    : 1.0  initial release
// ============================================================================
module prm_edge_chk_sched #(
  parameter int NUM_EDGE = 16,
  parameter int CODE_W   = 15,
  parameter int ADDR_W   = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W:0]     obs_count,
  input  logic [NUM_EDGE-1:0] edge_en,
  output logic                busy,
  output logic                done,
  output logic [NUM_EDGE-1:0] edge_blocked,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [CODE_W-1:0]   mem_rdata,
  output logic [CODE_W-1:0]   chk_code,
  output logic                chk_valid,
  input  logic [NUM_EDGE-1:0] chk_mask
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] c_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W:0]     r_count;
  logic [NUM_EDGE-1:0] r_en;
  logic [NUM_EDGE-1:0] r_acc;
  logic [NUM_EDGE-1:0] r_blocked;
  logic                r_rd_d1;     // a read was issued last cycle; data is on mem_rdata now
  logic                r_chk_valid;
  logic [CODE_W-1:0]   r_code;

  logic                w_start_ok;
  logic                w_active;
  logic                w_last;
  logic                w_cover;
  logic                w_flush;
  logic [NUM_EDGE-1:0] w_acc_nxt;

  assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_active   = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign w_last     = ({1'b0, r_cnt} == (r_count - c_ONE));
  // Include the mask arriving this cycle so early exit does not wait for the
  // accumulator register to catch up.
  assign w_acc_nxt  = r_acc | (r_chk_valid ? chk_mask : {NUM_EDGE{1'b0}});
  assign w_cover    = (r_en != {NUM_EDGE{1'b0}}) && ((w_acc_nxt & r_en) == r_en);
  // Abort or early exit discards whatever reads are still in flight.
  assign w_flush    = w_active && (abort || w_cover);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_ok) begin
          w_state_nxt = (obs_count == '0) ? ST_DONE : ST_ISSUE;
        end else if (r_state == ST_DONE) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (abort)        w_state_nxt = ST_IDLE;
        else if (w_cover) w_state_nxt = ST_DONE;
        else if (w_last)  w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Once no read is pending, the final code is on the checker this cycle.
        if (abort)        w_state_nxt = ST_IDLE;
        else if (w_cover) w_state_nxt = ST_DONE;
        else if (!r_rd_d1) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_count     <= '0;
      r_en        <= '0;
      r_acc       <= '0;
      r_blocked   <= '0;
      r_rd_d1     <= 1'b0;
      r_chk_valid <= 1'b0;
      r_code      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rd_d1     <= (r_state == ST_ISSUE) && !w_flush;
      r_chk_valid <= r_rd_d1 && !w_flush;
      if (r_rd_d1) begin
        r_code <= mem_rdata;
      end

      if (w_start_ok) begin
        r_cnt     <= '0;
        r_count   <= obs_count;
        r_en      <= edge_en;
        r_acc     <= '0;
        r_blocked <= '0;
      end else if (w_active) begin
        if (r_state == ST_ISSUE) begin
          r_cnt <= r_cnt + 1'b1;
        end
        r_acc <= w_acc_nxt;
        if (abort) begin
          r_blocked <= '0;
        end else if (w_state_nxt == ST_DONE) begin
          r_blocked <= w_acc_nxt & r_en;
        end
      end
    end
  end

  assign busy         = w_active;
  assign done         = (r_state == ST_DONE);
  assign edge_blocked = r_blocked;
  assign mem_rd_en    = (r_state == ST_ISSUE);
  assign mem_addr     = r_cnt;
  assign chk_code     = r_code;
  assign chk_valid    = r_chk_valid;

endmodule
`default_nettype wire

// File: tb/tb_prm_edge_chk_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_prm_edge_chk_sched
// Description : Self-checking bench for prm_edge_chk_sched. Models obstacle
//               RAM and the checker bank (code -> mask table), predicts each
//               query's result into a scoreboard queue and compares when the
//               DUT signals done.
// Revision    : 1.0  initial release
// ============================================================================
module tb_prm_edge_chk_sched;

  localparam int NUM_EDGE = 16;
  localparam int CODE_W   = 15;
  localparam int ADDR_W   = 10;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [ADDR_W:0]     obs_count = '0;
  logic [NUM_EDGE-1:0] edge_en = '0;
  logic                busy, done, mem_rd_en, chk_valid;
  logic [NUM_EDGE-1:0] edge_blocked, chk_mask;
  logic [ADDR_W-1:0]   mem_addr;
  logic [CODE_W-1:0]   mem_rdata = '0;
  logic [CODE_W-1:0]   chk_code;

  logic [CODE_W-1:0]   ram      [0:(1<<ADDR_W)-1];
  logic [NUM_EDGE-1:0] mask_tab [0:(1<<CODE_W)-1];

  typedef struct {
    int                  lat;
    logic [NUM_EDGE-1:0] blk;
    int                  reads;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  prm_edge_chk_sched #(.NUM_EDGE(NUM_EDGE), .CODE_W(CODE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .obs_count(obs_count), .edge_en(edge_en), .busy(busy), .done(done),
    .edge_blocked(edge_blocked), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .chk_code(chk_code), .chk_valid(chk_valid),
    .chk_mask(chk_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];
  // The checker answers for whatever code is presented, valid or not.
  assign chk_mask = mask_tab[chk_code];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int n, input logic [NUM_EDGE-1:0] en);
    exp_t e;
    logic [NUM_EDGE-1:0] acc = '0;
    int k = -1;
    for (int i = 0; i < n; i++) begin
      acc |= mask_tab[ram[i]];
      if (en != 0 && (acc & en) == en) begin
        k = i;
        break;
      end
    end
    if (n == 0) begin
      e.lat = 1; e.reads = 0; e.blk = '0;
    end else if (k < 0) begin
      e.lat = n + 3; e.reads = n; e.blk = acc & en;
    end else begin
      e.lat   = (k + 4 < n + 3) ? k + 4 : n + 3;
      e.reads = (k + 3 < n) ? k + 3 : n;
      e.blk   = acc & en;
    end
    return e;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_rden"}, {31'd0, mem_rd_en}, 0);
    check({tag, "_cval"}, {31'd0, chk_valid}, 0);
    check({tag, "_blk"},  {16'd0, edge_blocked}, 0);
    check({tag, "_addr"}, {22'd0, mem_addr}, 0);
    check({tag, "_code"}, {17'd0, chk_code}, 0);
  endtask

  // One query: push prediction, launch, monitor reads, compare at done.
  task automatic run_query(input string tag, input int n, input logic [NUM_EDGE-1:0] en,
                           input int busy_start_at);
    exp_t e;
    int rd = 0, seq_bad = 0, got = 0;
    @(negedge clk);
    obs_count = n[ADDR_W:0];
    edge_en   = en;
    start     = 1'b1;
    sb.push_back(model(n, en));
    for (int c = 1; c <= n + 20 && got == 0; c++) begin
      @(negedge clk);
      start = (c == busy_start_at);
      if (start) begin
        obs_count = 2;
        edge_en   = 16'h0001;
      end
      if (mem_rd_en) begin
        if (int'(mem_addr) != rd) seq_bad++;
        rd++;
      end
      if (done) begin
        got = 1;
        e = sb.pop_front();
        check({tag, "_lat"},   c, e.lat);
        check({tag, "_blk"},   {16'd0, edge_blocked}, {16'd0, e.blk});
        check({tag, "_reads"}, rd, e.reads);
        check({tag, "_aseq"},  seq_bad, 0);
      end
    end
    start = 1'b0;
    if (got == 0) begin
      check({tag, "_timeout"}, 0, 1);
      void'(sb.pop_front());
    end else begin
      @(negedge clk);
      check({tag, "_done1"}, {31'd0, done}, 0);
      check({tag, "_hold"},  {16'd0, edge_blocked}, {16'd0, e.blk});
    end
  endtask

  initial begin
    int dn;
    for (int i = 0; i < (1 << CODE_W); i++) mask_tab[i] = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 15'd1;
    mask_tab[0] = 16'hFFFF;   // code after reset; must never leak in unqualified

    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic three-code scan.
    ram[0] = 15'd101; ram[1] = 15'd102; ram[2] = 15'd103;
    mask_tab[101] = 16'h0001; mask_tab[102] = 16'h0100; mask_tab[103] = 16'h0000;
    run_query("t1", 3, 16'hFFFF, 0);

    // Empty list.
    run_query("t2", 0, 16'hFFFF, 0);

    // Early exit on the second code.
    for (int i = 0; i < 100; i++) ram[i] = CODE_W'(200 + i);
    mask_tab[200] = 16'h0010;
    mask_tab[201] = 16'h0003;
    run_query("t3", 100, 16'h0003, 0);

    // Abort on the fifth issue cycle.
    @(negedge clk);
    obs_count = 20; edge_en = 16'hFFFF; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("ab_rden5", {31'd0, mem_rd_en}, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", {31'd0, busy}, 0);
    check("ab_done", {31'd0, done}, 0);
    check("ab_blk",  {16'd0, edge_blocked}, 0);
    dn = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("ab_nodone", dn, 0);
    run_query("t4", 5, 16'hFFFF, 0);

    // Start pulsed while busy must not disturb the running query.
    run_query("t5", 10, 16'hFFFF, 3);

    // Reset mid-scan.
    @(negedge clk);
    obs_count = 50; edge_en = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("mrst");
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("mrst_nodone", dn, 0);

    // Full address range, no early exit possible (bit 15 never set).
    for (int i = 0; i < 1024; i++) begin
      ram[i] = CODE_W'(1000 + i);
      mask_tab[1000 + i] = (($urandom_range(0, 15) == 0) ? NUM_EDGE'($urandom) : 16'h0) & 16'h7FFF;
    end
    run_query("t6", 1024, 16'hFFFF, 0);

    // Random queries with sparse masks and varied edge sets.
    for (int q = 0; q < 8; q++) begin
      int n;
      logic [NUM_EDGE-1:0] en;
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        ram[i] = CODE_W'(3000 + 64 * q + i);
        mask_tab[3000 + 64 * q + i] = NUM_EDGE'(1) << $urandom_range(0, 15);
      end
      case (q % 4)
        0: en = 16'h0000;
        1: en = NUM_EDGE'(1) << $urandom_range(0, 15);
        2: en = NUM_EDGE'($urandom) & 16'h000F;
        default: en = NUM_EDGE'($urandom);
      endcase
      run_query($sformatf("rnd%0d", q), n, en, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
